// File: rtl/layer_compositor_pipe.sv
// Priority compositor: merges NUM_LAYERS layers over a background with 2-cycle latency and per-frame collision report.
// Optional 50% blend of the winner with the layer beneath it when LAYER_COMPOSITOR_BLEND_EN is defined.
module layer_compositor_pipe #(
  parameter int NUM_LAYERS = 16,
  parameter int COLOR_W    = 8,
  localparam int IDX_W     = $clog2(NUM_LAYERS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_pix_valid,
  input  logic                              i_v_sync,
  input  logic [NUM_LAYERS-1:0]             i_layer_en,
  input  logic [NUM_LAYERS-1:0]             i_layer_hit,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   i_layer_rgb,
  input  logic [3*COLOR_W-1:0]              i_bg_rgb,
  input  logic [NUM_LAYERS-1:0]             i_blend,
  output logic                              o_pix_valid,
  output logic                              o_v_sync,
  output logic [COLOR_W-1:0]                o_red,
  output logic [COLOR_W-1:0]                o_green,
  output logic [COLOR_W-1:0]                o_blue,
  output logic [IDX_W-1:0]                  o_top_layer,
  output logic                              o_bg,
  output logic [NUM_LAYERS-1:0]             o_collide,
  output logic                              o_collide_stb
);

  localparam int PIX_W = 3*COLOR_W;

  logic [NUM_LAYERS-1:0] vis;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic                  under_found;
  logic [IDX_W-1:0]      under_idx;
  logic [PIX_W-1:0]      win_rgb;
  logic [PIX_W-1:0]      under_rgb;

  assign vis = i_layer_hit & i_layer_en;

  // Scan from lowest priority upward; each new hit pushes the previous winner down to "under".
  always_comb begin
    win_found   = 1'b0;
    win_idx     = '0;
    under_found = 1'b0;
    under_idx   = '0;
    for (int k = NUM_LAYERS-1; k >= 0; k--) begin
      if (vis[k]) begin
        under_found = win_found;
        under_idx   = win_idx;
        win_found   = 1'b1;
        win_idx     = k[IDX_W-1:0];
      end
    end
  end

  assign win_rgb   = win_found   ? i_layer_rgb[win_idx*PIX_W +: PIX_W]   : i_bg_rgb;
  assign under_rgb = under_found ? i_layer_rgb[under_idx*PIX_W +: PIX_W] : i_bg_rgb;

  logic             s1_valid;
  logic             s1_vs;
  logic             s1_bg;
  logic             s1_blend;
  logic [IDX_W-1:0] s1_idx;
  logic [PIX_W-1:0] s1_win_rgb;
  logic [PIX_W-1:0] s1_under_rgb;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid     <= 1'b0;
      s1_vs        <= 1'b0;
      s1_bg        <= 1'b0;
      s1_blend     <= 1'b0;
      s1_idx       <= '0;
      s1_win_rgb   <= '0;
      s1_under_rgb <= '0;
    end else begin
      s1_valid     <= i_pix_valid;
      s1_vs        <= i_v_sync;
      s1_bg        <= ~win_found;
      s1_blend     <= win_found & i_blend[win_idx];
      s1_idx       <= win_idx;
      s1_win_rgb   <= win_rgb;
      s1_under_rgb <= under_rgb;
    end
  end

  logic [PIX_W-1:0] final_rgb;

`ifdef LAYER_COMPOSITOR_BLEND_EN
  logic [PIX_W-1:0] blend_rgb;

  for (genvar c = 0; c < 3; c++) begin : g_avg
    logic unused_lsb;
    assign {blend_rgb[c*COLOR_W +: COLOR_W], unused_lsb} =
      {1'b0, s1_win_rgb[c*COLOR_W +: COLOR_W]} + {1'b0, s1_under_rgb[c*COLOR_W +: COLOR_W]};
  end

  assign final_rgb = (s1_blend && !s1_bg) ? blend_rgb : s1_win_rgb;
`else
  logic unused_blend;
  assign unused_blend = s1_blend ^ (^s1_under_rgb);
  assign final_rgb    = s1_win_rgb;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pix_valid <= 1'b0;
      o_v_sync    <= 1'b0;
      o_red       <= '0;
      o_green     <= '0;
      o_blue      <= '0;
      o_top_layer <= '0;
      o_bg        <= 1'b0;
    end else begin
      o_pix_valid <= s1_valid;
      o_v_sync    <= s1_vs;
      o_red       <= final_rgb[3*COLOR_W-1:2*COLOR_W];
      o_green     <= final_rgb[2*COLOR_W-1:COLOR_W];
      o_blue      <= final_rgb[COLOR_W-1:0];
      o_top_layer <= s1_idx;
      o_bg        <= s1_bg;
    end
  end

  logic                    vs_q;
  logic                    rise;
  logic [NUM_LAYERS-1:1]   coll_acc;
  logic [NUM_LAYERS-1:1]   coll_new;

  assign rise     = i_v_sync & ~vs_q;
  assign coll_new = (i_pix_valid && vis[0]) ? vis[NUM_LAYERS-1:1] : '0;

  // The pixel arriving with the v_sync rise belongs to the new frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vs_q          <= 1'b1;
      coll_acc      <= '0;
      o_collide     <= '0;
      o_collide_stb <= 1'b0;
    end else begin
      vs_q          <= i_v_sync;
      o_collide_stb <= rise;
      if (rise) begin
        o_collide <= {coll_acc, |coll_acc};
        coll_acc  <= coll_new;
      end else begin
        coll_acc  <= coll_acc | coll_new;
      end
    end
  end

endmodule
